board_io_cond: RTL

- Parametrised board-level I/O conditioning block between FPGA pins/PLL and the sigma SoC on Nexys-class boards.
- Replaces ad-hoc top-level glue:
  - generates the SoC reset from raw reset plus PLL lock, with a hold-off counter;
  - debounces N buttons and provides press/release pulses;
  - synchronises N switches;
  - drives N LEDs through a global PWM dimmer.

---
 rtl/board_io_cond.sv | 133 +++++++++++++
 1 files changed

// File: rtl/board_io_cond.sv
// Board-level I/O conditioning between FPGA pins/PLL and the SoC: reset sequencing,
// button debounce with edge pulses, switch synchronisation and global LED PWM dimming.
module board_io_cond #(
    parameter int                 NUM_BTN         = 5,
    parameter logic [NUM_BTN-1:0] BTN_INV         = '0,
    parameter int                 DEBOUNCE_CYCLES = 800000,
    parameter int                 NUM_SW          = 16,
    parameter int                 NUM_LED         = 16,
    parameter int                 LED_DUTY        = 256,
    parameter int                 RST_HOLD_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               pll_locked_i,
    output logic               sys_rst_o,
    input  logic [NUM_BTN-1:0] btn_raw_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o,
    input  logic [NUM_SW-1:0]  sw_raw_i,
    output logic [NUM_SW-1:0]  sw_o,
    input  logic [NUM_LED-1:0] led_i,
    output logic [NUM_LED-1:0] led_o
);

    localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int                HOLD_W    = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [8:0]        DUTY      = 9'(LED_DUTY);

    localparam logic [0:0] ST_HOLD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic              lock_p0;
    logic              lock_s;
    logic [0:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              sys_rst;

    // Reset sequencer: release only after lock has been stable for the hold window
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lock_p0  <= 1'b0;
            lock_s   <= 1'b0;
            state    <= ST_HOLD;
            hold_cnt <= '0;
            sys_rst  <= 1'b1;
        end else begin
            lock_p0 <= pll_locked_i;
            lock_s  <= lock_p0;
            if (state == ST_HOLD) begin
                if (!lock_s) begin
                    hold_cnt <= '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state    <= ST_RUN;
                    sys_rst  <= 1'b0;
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end else if (!lock_s) begin
                state    <= ST_HOLD;
                sys_rst  <= 1'b1;
                hold_cnt <= '0;
            end
        end
    end

    logic [NUM_BTN-1:0] btn_p0;
    logic [NUM_BTN-1:0] btn_s;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [DB_W-1:0]    db_cnt [NUM_BTN];

    // Debounce: any disagreement with the accepted level must persist unbroken
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            btn_p0      <= '0;
            btn_s       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
        end else begin
            btn_p0      <= btn_raw_i ^ BTN_INV;
            btn_s       <= btn_p0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_s[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_level[i]   <= btn_s[i];
                    btn_press[i]   <= btn_s[i];
                    btn_release[i] <= ~btn_s[i];
                    db_cnt[i]      <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    logic [NUM_SW-1:0]  sw_p0;
    logic [NUM_SW-1:0]  sw_s;
    logic [7:0]         pwm_cnt;
    logic [NUM_LED-1:0] led_q;

    // Switch synchroniser and LED dimmer
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sw_p0   <= '0;
            sw_s    <= '0;
            pwm_cnt <= '0;
            led_q   <= '0;
        end else begin
            sw_p0   <= sw_raw_i;
            sw_s    <= sw_p0;
            pwm_cnt <= pwm_cnt + 8'd1;
            led_q   <= led_i & {NUM_LED{({1'b0, pwm_cnt} < DUTY)}};
        end
    end

    assign sys_rst_o     = sys_rst;
    assign btn_level_o   = btn_level;
    assign btn_press_o   = btn_press;
    assign btn_release_o = btn_release;
    assign sw_o          = sw_s;
    assign led_o         = led_q;

endmodule
